// File: rtl/fifo_drain.sv
// fifo_drain: read-side consumer for a FIFO output port, in the FIFO read clock domain.
//
// It watches the FIFO empty flag and issues single-cycle read enables. It captures
// the read data one cycle after each enable. It presents the captured words on a
// valid/ready stream through a 2-entry skid buffer, and it counts the delivered beats.
//
// Ports:
//   clk        read-domain clock (FIFO read clock)
//   arst       asynchronous reset, active-low
//   en         drain enable; 1 = fetch words from the FIFO
//   fifo_empty FIFO empty flag
//   fifo_rd_en read enable to the FIFO, one word per high cycle
//   fifo_data  FIFO read data, valid in the cycle after fifo_rd_en=1
//   m_data     stream data (oldest buffered word)
//   m_valid    stream valid
//   m_ready    stream ready from downstream
//   busy       1 while the drain is running or finishing (RUN or STOP)
//   words_out  count of accepted stream beats, wraps modulo 2^CNT_W
//
// Stream handshake: a beat transfers on every rising clk edge where
// m_valid=1 and m_ready=1. While m_valid=1 and m_ready=0, m_data is held stable.
// m_valid never depends combinationally on m_ready.
module fifo_drain #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [N-1:0]     fifo_data,
    output logic [N-1:0]     m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic [CNT_W-1:0] words_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     occ;       // buffered words, 0..2
    logic           inflight;  // a read was issued last cycle; its word lands this edge
    logic [N-1:0]   head;      // oldest buffered word
    logic [N-1:0]   tail;      // second word, meaningful only when occ==2
    logic           pop;
    logic           credit;

    assign pop = m_valid & m_ready;

    // Count an outstanding read as already buffered. This keeps occ+inflight <= 2.
    // A pop in the same cycle frees one slot, so a read may still be issued
    // when the buffer is full and this keeps the stream at full rate.
    assign credit     = ({1'b0, occ} + {2'b00, inflight}) < 3'd2;
    assign fifo_rd_en = (state == RUN) & ~fifo_empty & (credit | pop);

    assign m_valid = (occ != 2'd0);
    assign m_data  = head;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en) state_nxt = RUN;
            RUN:  if (!en) state_nxt = STOP;
            // Stay in STOP until the outstanding read has landed and every
            // buffered word has been handed downstream.
            STOP: begin
                if (occ == 2'd0 && !inflight) state_nxt = IDLE;
                else if (en)                  state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state     <= IDLE;
            inflight  <= 1'b0;
            words_out <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_rd_en;
            if (pop) words_out <= words_out + 1'b1;
        end
    end

    // Skid buffer. A pop always shifts tail into head. A capture writes the
    // first free slot after that shift.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= fifo_data;
                    else             tail <= fifo_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= fifo_data;
                    end else begin
                        head <= tail;
                        tail <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: bench for fifo_drain with CNT_W=4, so the counter wraps.
// A queue models the FIFO. Each word the model presents on fifo_data is
// pushed to exp_q, and each stream beat pops exp_q and is compared against it.
module tb_fifo_drain;

    localparam int N     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             en = 1'b0;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd_en;
    logic [N-1:0]     fifo_data = '0;
    logic [N-1:0]     m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] words_out;

    always #5 clk = ~clk;

    fifo_drain #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .arst       (rst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .words_out  (words_out)
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0] fifo_q[$];
    logic [N-1:0] exp_q[$];

    logic rd_s = 1'b0;
    int   cyc = 0;
    int   rd_cnt = 0;
    int   cur_run = 0;
    int   max_run = 0;
    int   delivered = 0;
    int   first_beat = -1;
    int   last_beat = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: samples settled outputs on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            rd_s = 1'b0;
        end else begin
            rd_s = fifo_rd_en;
            if (fifo_rd_en) begin
                rd_cnt++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
                check("rd_nonempty", 32'(fifo_empty), 32'd0);
            end else begin
                cur_run = 0;
            end
            check("occ_bound", 32'(dut.occ <= 2'd2), 32'd1);
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'(m_valid), 32'd0);
                end else begin
                    check("m_data", 32'(m_data), 32'(exp_q[0]));
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        delivered++;
                        if (first_beat < 0) first_beat = cyc;
                        last_beat = cyc;
                    end
                end
            end
        end
    end

    // FIFO model: data for a read issued in cycle k appears just after edge k+1.
    always @(posedge clk) begin
        #1;
        if (rst_n && rd_s && fifo_q.size() > 0) begin
            fifo_data = fifo_q.pop_front();
            exp_q.push_back(fifo_data);
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [N-1:0] base);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + N'(i));
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_words", 32'(words_out), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        en = 1'b0;
        m_ready = 1'b0;
        fifo_empty = 1'b1;
        rd_s = 1'b0;
        rd_cnt = 0;
        cur_run = 0;
        max_run = 0;
        delivered = 0;
        first_beat = -1;
        last_beat = -1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic wait_delivered(input int n, input int budget);
        int t = 0;
        while (delivered < n && t < budget) begin
            step(1);
            t++;
        end
        check("delivered", 32'(delivered), 32'(n));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        do_reset();

        // Full-rate stream
        load(8, 8'h01);
        m_ready = 1'b1;
        en = 1'b1;
        wait_delivered(8, 60);
        check("full_rd_run", 32'(max_run), 32'd8);
        check("full_beat_span", 32'(last_beat - first_beat), 32'd7);
        step(2);
        check("full_words", 32'(words_out), 32'd8);
        check("full_busy", 32'(busy), 32'd1);
        check("full_valid_low", 32'(m_valid), 32'd0);

        // Back-pressure
        do_reset();
        load(4, 8'h01);
        en = 1'b1;
        step(12);
        check("bp_reads", 32'(rd_cnt), 32'd2);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_hold", 32'(m_data), 32'h01);
        check("bp_rd_low", 32'(fifo_rd_en), 32'd0);
        m_ready = 1'b1;
        wait_delivered(4, 40);
        step(1);
        check("bp_words", 32'(words_out), 32'd4);

        // Toggled ready
        do_reset();
        load(6, 8'h10);
        en = 1'b1;
        for (int i = 0; i < 80 && delivered < 6; i++) begin
            m_ready = ~m_ready;
            step(1);
        end
        check("tog_delivered", 32'(delivered), 32'd6);
        step(3);
        check("tog_words", 32'(words_out), 32'd6);
        check("tog_exp_empty", 32'(exp_q.size()), 32'd0);

        // Empty guard
        do_reset();
        en = 1'b1;
        m_ready = 1'b1;
        step(20);
        check("empty_reads", 32'(rd_cnt), 32'd0);
        check("empty_valid", 32'(m_valid), 32'd0);
        check("empty_busy", 32'(busy), 32'd1);
        en = 1'b0;
        step(3);
        check("empty_idle", 32'(busy), 32'd0);

        // Disable mid-burst: en drops in the cycle after the first read
        do_reset();
        load(8, 8'h20);
        en = 1'b1;
        for (int i = 0; i < 10 && rd_cnt == 0; i++) step(1);
        check("dis_first_rd", 32'(rd_cnt), 32'd1);
        en = 1'b0;
        step(6);
        check("dis_reads", 32'(rd_cnt), 32'd2);
        check("dis_busy_hold", 32'(busy), 32'd1);
        check("dis_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        wait_delivered(2, 20);
        step(3);
        check("dis_busy_low", 32'(busy), 32'd0);
        check("dis_words", 32'(words_out), 32'd2);
        check("dis_fifo_left", 32'(fifo_q.size()), 32'd6);

        // Counter wrap, then reset mid-stream
        do_reset();
        load(17, 8'h40);
        en = 1'b1;
        for (int i = 0; i < 200 && delivered < 17; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            step(1);
        end
        check("wrap_delivered", 32'(delivered), 32'd17);
        m_ready = 1'b0;
        step(3);
        check("wrap_words", 32'(words_out), 32'd1);
        load(8, 8'h80);
        m_ready = 1'b1;
        wait_delivered(20, 40);
        check("mid_valid", 32'(m_valid), 32'd1);
        do_reset();
        step(3);
        check("post_rst_valid", 32'(m_valid), 32'd0);
        check("post_rst_words", 32'(words_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
